// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS control sequencer:
// state encoding, opcodes, mux selects and the control vector.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal(
    input logic [5:0] op
  );
    return (op == OP_R)   || (op == OP_LW)  ||
           (op == OP_SW)  || (op == OP_BEQ) ||
           (op == OP_J)   || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control decode: current state plus the
// memory handshake and ALU zero flag give the control vector.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.i_or_d    = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      S_DECODE: begin
        // branch target is precomputed into ALUOut here
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.illegal   = ~is_legal(opcode_i);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
      end
      S_ADDI_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_source = PCSRC_ALUOUT;
        ctrl_o.pc_en     = zero_i;
      end
      S_JUMP: begin
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.pc_en     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control: state register, next-state
// sequencing on the memory handshake, and retired counter.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  ctrl_t            ctrl;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB,
      S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .ctrl_o      (ctrl)
  );

  // architectural writes are suppressed for the whole reset window
  assign pc_en      = ctrl.pc_en     & ~rst;
  assign ir_write   = ctrl.ir_write  & ~rst;
  assign reg_write  = ctrl.reg_write & ~rst;
  assign mem_write  = ctrl.mem_write & ~rst;
  assign pc_source  = ctrl.pc_source;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal    = ctrl.illegal;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: instruction-sequence model,
// directed latency/reset cases, then randomized traffic.
module tb_mips_mc_control;

  localparam int CW = 4;

  localparam int F = 0, D = 1, MA = 2, MRD = 3, MWB = 4, MWR = 5;
  localparam int REX = 6, RWB = 7, BR = 8, JP = 9, AEX = 10, AWB = 11;
  localparam int C_R = 0, C_ADDI = 1, C_LW = 2, C_SW = 3;
  localparam int C_BEQ = 4, C_J = 5, C_ILL = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    op = 6'd0;
  logic          zero = 1'b0;
  logic          mr = 1'b0;
  logic          pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic          reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]    pc_source, alu_src_b, alu_op;
  logic [CW-1:0] retired;
  logic [3:0]    state;
  logic [15:0]   dut_vec;

  int checks = 0;
  int passes = 0;
  int m_cls = C_R;
  int m_k = 0;
  int m_ret = 0;
  int ill_seen = 0;

  always #5 clk = ~clk;

  mips_mc_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(op), .zero(zero),
    .mem_ready(mr), .pc_en(pc_en), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .retired(retired), .state(state)
  );

  assign dut_vec = {pc_en, pc_source, i_or_d, mem_read,
                    mem_write, ir_write, reg_write, reg_dst,
                    mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    illegal};

  function automatic int classify(input logic [5:0] o);
    case (o)
      6'b000000: return C_R;
      6'b001000: return C_ADDI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  // Each instruction class is just an ordered list of steps.
  function automatic int seq_len(input int c);
    case (c)
      C_LW:         return 5;
      C_R, C_ADDI,
      C_SW:         return 4;
      C_BEQ, C_J:   return 3;
      default:      return 2;
    endcase
  endfunction

  function automatic int step_of(input int c, input int k);
    if (k == 0) return F;
    if (k == 1) return D;
    case (c)
      C_R:    return (k == 2) ? REX : RWB;
      C_ADDI: return (k == 2) ? AEX : AWB;
      C_LW:   return (k == 2) ? MA : ((k == 3) ? MRD : MWB);
      C_SW:   return (k == 2) ? MA : MWR;
      C_BEQ:  return BR;
      default: return JP;
    endcase
  endfunction

  function automatic logic [15:0] exp_vec(
    input int s, input int c, input logic m,
    input logic z, input logic r
  );
    logic       pe, iod, rd, wr, irw, rw, rdst, m2r, sa, il;
    logic [1:0] ps, sb, ao;
    {pe, iod, rd, wr, irw, rw, rdst, m2r, sa, il} = '0;
    {ps, sb, ao} = '0;
    case (s)
      F:   begin rd = 1; sb = 2'b01; irw = m; pe = m; end
      D:   begin sb = 2'b11; il = (c == C_ILL); end
      MA:  begin sa = 1; sb = 2'b10; end
      MRD: begin rd = 1; iod = 1; end
      MWB: begin rw = 1; m2r = 1; end
      MWR: begin wr = 1; iod = 1; end
      REX: begin sa = 1; ao = 2'b10; end
      RWB: begin rw = 1; rdst = 1; end
      AEX: begin sa = 1; sb = 2'b10; end
      AWB: begin rw = 1; end
      BR:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
      default: begin ps = 2'b10; pe = 1; end
    endcase
    if (r) begin pe = 0; irw = 0; rw = 0; wr = 0; end
    return {pe, ps, iod, rd, wr, irw, rw, rdst, m2r, sa,
            sb, ao, il};
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic advance();
    int s;
    if (rst) begin m_k = 0; m_ret = 0; return; end
    s = step_of(m_cls, m_k);
    if ((s == F || s == MRD || s == MWR) && !mr) return;
    if (m_k == 0) begin
      m_cls = classify(op);
      m_k = 1;
    end else if (m_k == seq_len(m_cls) - 1) begin
      m_k = 0;
      if (m_cls != C_ILL) m_ret = (m_ret + 1) % (1 << CW);
    end else begin
      m_k++;
    end
  endtask

  // Called at posedge+1 with inputs set; compares at negedge.
  task automatic tick();
    int s;
    logic [CW-1:0] er;
    if (rst) begin m_k = 0; m_ret = 0; end
    #4;
    s = step_of(m_cls, m_k);
    er = m_ret[CW-1:0];
    chk($sformatf("ctrl step%0d", s), dut_vec,
        exp_vec(s, m_cls, mr, zero, rst));
    chk("retired", retired, er);
    if (illegal === 1'b1) ill_seen++;
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic run_instr(input logic [5:0] o, input int waits,
                           input logic z, output int cyc);
    int w = 0;
    int s;
    cyc = 0;
    op = o;
    zero = z;
    do begin
      s = step_of(m_cls, m_k);
      if (s == MRD || s == MWR) begin
        mr = (w < waits) ? 1'b0 : 1'b1;
        if (w < waits) w++;
      end else if (s == F) mr = 1'b1;
      else mr = 1'($urandom % 2);
      tick();
      cyc++;
    end while (m_k != 0 && cyc < 50);
  endtask

  initial begin
    int cyc;
    int il0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mr = 1'b1;
    tick();
    chk("reset retired", retired, 0);
    chk("reset illegal", illegal, 0);
    chk("reset pc_en", pc_en, 0);
    chk("reset ir_write", ir_write, 0);
    rst = 1'b0;

    run_instr(6'b000000, 0, 1'b0, cyc);
    chk("R cycles", cyc, 4);
    chk("R retired", retired, 1);
    run_instr(6'b100011, 3, 1'b0, cyc);
    chk("lw wait cycles", cyc, 8);
    chk("lw retired", retired, 2);
    run_instr(6'b000100, 0, 1'b1, cyc);
    chk("beq taken cycles", cyc, 3);
    run_instr(6'b000100, 0, 1'b0, cyc);
    chk("beq fall cycles", cyc, 3);
    chk("beq retired", retired, 4);
    run_instr(6'b000010, 0, 1'b0, cyc);
    chk("j cycles", cyc, 3);
    chk("j retired", retired, 5);
    il0 = ill_seen;
    run_instr(6'b111111, 0, 1'b0, cyc);
    chk("illegal cycles", cyc, 2);
    chk("illegal pulses", ill_seen - il0, 1);
    chk("illegal retired", retired, 5);
    run_instr(6'b101011, 0, 1'b0, cyc);
    chk("sw cycles", cyc, 4);
    run_instr(6'b001000, 0, 1'b0, cyc);
    chk("addi cycles", cyc, 4);
    chk("addi retired", retired, 7);

    op = 6'b100011;
    mr = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrd retired", retired, 0);
    chk("midrd reg_write", reg_write, 0);
    chk("midrd pc_en", pc_en, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom % 150 == 0);
      mr = ($urandom % 4 != 0);
      zero = 1'($urandom % 2);
      if (m_k == 0) begin
        case ($urandom % 8)
          0: op = 6'b000000;
          1: op = 6'b100011;
          2: op = 6'b101011;
          3: op = 6'b000100;
          4: op = 6'b000010;
          5: op = 6'b001000;
          default: op = 6'($urandom);
        endcase
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
